muldiv_sequencer: RTL
=====================

# muldiv_sequencer

Multi-cycle sequencer for the pipeline's integer multiply/divide unit. It accepts MULT, MULTU, DIV and DIVU from the EX stage and runs an iterative shift-add multiply or restoring divide over WIDTH cycles. The result is written into its internal HI/LO registers. While an operation is in flight, the block stalls the pipeline for any dependent HI/LO read or any new mult/div issue.

## Interface
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.
- Clk  input  1  single clock, rising edge.
- Rst_n  input  1  reset, asynchronous, active-low.
- Start  input  1  EX stage holds a valid mult/div instruction this cycle.
- Funct  input  6  R-type function field: 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU.
- A  input  WIDTH  rs operand (multiplicand / dividend).
- B  input  WIDTH  rt operand (multiplier / divisor).
- HiLoRead  input  1  EX stage holds MFHI/MFLO this cycle.
- Flush  input  1  pipeline flush; abort any operation in flight.
- Busy  output  1  operation in flight (states PREP, RUN, FIXUP).
- Stall  output  1  combinational: Busy & (Start | HiLoRead).
- Done  output  1  one-cycle pulse; HI/LO hold the new result.
- DivByZero  output  1  valid with Done; 1 if a divide had B == 0.
- Hi  output  WIDTH  HI register.
- Lo  output  WIDTH  LO register.

## Operation
- **FSM states:** IDLE, PREP, RUN, FIXUP, DONE.
- **Accepting an op:**
  - IDLE or DONE, with Start=1, a legal Funct and Flush=0: latch the op and signed flag, go to PREP.
  - Start with any other Funct is ignored.
  - In DONE with no accepted Start, go to IDLE.
- **PREP:**
  - Signed ops: latch |A| and |B|, and record the result signs.
    - Quotient sign = sign(A) xor sign(B).
    - Product sign = sign(A) xor sign(B).
    - Remainder sign = sign(A).
  - Unsigned ops: latch A and B unchanged.
  - Clear the 2*WIDTH accumulator, load the iteration counter with WIDTH, go to RUN.
- **RUN:** one iteration per cycle; the counter decrements; go to FIXUP when the counter reaches 1.
  - Multiply: LSB-first shift-add into the 2*WIDTH accumulator.
  - Divide: restoring shift-subtract. The quotient builds in the low half and the partial remainder in the high half.
- **FIXUP:**
  - Negate the result if its sign flag is set.
  - Write HI/LO:
    - Multiply: HI = product[2W-1:W], LO = product[W-1:0].
    - Divide: LO = quotient, HI = remainder.
  - Go to DONE.
- **DONE:** Done=1 for exactly this cycle; Busy=0.
- **Division rules:**
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Signed 0x80000000 / -1: LO = 0x80000000, HI = 0 (wraps, no flag).
- **Divide by zero (B == 0):**
  - Still runs the full latency.
  - LO = all ones, HI = A (the original operand, signed or unsigned).
  - DivByZero=1 in the DONE cycle.
- **Flush:**
  - In any state, go to IDLE at the next edge.
  - HI/LO are not written; no Done.
  - Flush overrides a simultaneous Start.
- **Start while Busy:** ignored by the sequencer; the pipeline holds the instruction via Stall and re-presents it.
- **Reset (asynchronous, any time including mid-operation):**
  - State = IDLE.
  - Hi = 0, Lo = 0.
  - Busy = 0, Done = 0, DivByZero = 0.
  - Accumulator and counter = 0.

## Timing
- **Latency:** with Start accepted at edge k:
  - PREP during cycle k+1.
  - RUN during cycles k+2 .. k+WIDTH+1.
  - FIXUP during cycle k+WIDTH+2.
  - HI/LO updated at the edge ending FIXUP.
  - Done high during cycle k+WIDTH+3 (35 cycles after the issue edge for WIDTH=32).
- **Busy:** high from cycle k+1 through FIXUP.
- **Stall:** a HiLoRead or a new Start presented during Busy stalls until the DONE cycle, where Stall=0 and Hi/Lo already show the new result.
- **Back-to-back ops:** a Start accepted in the DONE cycle begins the next op at that edge; its PREP follows immediately.
- **Output registers:** Hi, Lo, Done and DivByZero are registered; Stall is the only combinational output.

## Test plan
1. **Signed multiply:** MULT A=7, B=0xFFFFFFFD.
   - Done exactly 35 cycles after the issue edge.
   - Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
   - Busy high for 34 cycles.
2. **Unsigned multiply, then signed multiply back-to-back:** MULTU A=B=0xFFFFFFFF.
   - Hi=0xFFFFFFFE, Lo=0x00000001.
   - MULT of the same operands, issued in the DONE cycle, gives Hi=0, Lo=1.
3. **Divide:**
   - DIV A=-7 (0xFFFFFFF9), B=2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
   - DIVU A=7, B=2 → Lo=3, Hi=1.
   - DIV 0x80000000 / 0xFFFFFFFF → Lo=0x80000000, Hi=0.
4. **Divide by zero:**
   - DIVU A=5, B=0 → Lo=0xFFFFFFFF, Hi=5, DivByZero=1 only in the Done cycle.
   - DIV A=0xFFFFFFFB, B=0 → Lo=0xFFFFFFFF, Hi=0xFFFFFFFB.
5. **Flush and reset mid-operation:**
   - Set Hi=0x11, Lo=0x22 via a prior op, start MULT, assert Flush in RUN cycle 10 → Busy=0 next cycle, no Done, Hi/Lo unchanged.
   - Repeat with Rst_n pulsed low mid-RUN (not clock-aligned) → all outputs 0 immediately.
6. **Stall behaviour:**
   - Hold HiLoRead=1 during a DIV → Stall=1 every Busy cycle and 0 in the DONE cycle.
   - A second Start during Busy does not restart the op; Done timing is unaffected.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide sequencer for the integer pipeline: shift-add multiply,
// restoring divide, WIDTH iterations, results held in the HI/LO registers.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_lo_read,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic                 is_div, is_signed;
    logic [WIDTH-1:0]     a_raw, b_raw;
    logic [WIDTH-1:0]     opa, opb;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;
    logic                 neg_lo, neg_hi;

    logic                 legal, accept;
    logic [WIDTH:0]       mul_sum, div_part, div_diff;
    logic                 q_bit;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix;
    logic                 zero_div;

    assign legal  = funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
    assign accept = (state == S_IDLE || state == S_DONE) && start && legal && !flush;

    // State register
    // NOTE: every clocked process uses non-blocking assignments so all registers
    // update together from the values present before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic; flush wins over everything, including a same-cycle start
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (accept) state_next = S_PREP;
                S_PREP:  state_next = S_RUN;
                S_RUN:   if (cnt == CW'(1)) state_next = S_FIXUP;
                S_FIXUP: state_next = S_DONE;
                S_DONE:  state_next = accept ? S_PREP : S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Output decode
    always_comb begin
        busy  = (state == S_PREP) || (state == S_RUN) || (state == S_FIXUP);
        stall = busy && (start || hi_lo_read);
    end

    // One iteration of each algorithm; opb feeds multiplier bits LSB-first,
    // opa feeds dividend bits MSB-first into the partial remainder.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (opb[0] ? {1'b0, opa} : '0);
        div_part = {acc[2*WIDTH-1:WIDTH], opa[WIDTH-1]};
        div_diff = div_part - {1'b0, opb};
        q_bit    = ~div_diff[WIDTH];
        div_rem  = q_bit ? div_diff[WIDTH-1:0] : div_part[WIDTH-1:0];
    end

    always_comb begin
        prod_fix = neg_lo ? -acc : acc;
        quot_fix = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        zero_div = is_div && (b_raw == '0);
    end

    // Datapath and registered outputs
    // NOTE: all datapath state is in the async reset, not just the control bits,
    // so HI/LO and the accumulator read as zero immediately after any reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_div      <= 1'b0;
            is_signed   <= 1'b0;
            a_raw       <= '0;
            b_raw       <= '0;
            opa         <= '0;
            opb         <= '0;
            acc         <= '0;
            cnt         <= '0;
            neg_lo      <= 1'b0;
            neg_hi      <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            if (accept) begin
                is_div    <= funct[1];
                is_signed <= ~funct[0];
                a_raw     <= a;
                b_raw     <= b;
            end
            case (state)
                S_PREP: begin
                    opa    <= (is_signed && a_raw[WIDTH-1]) ? -a_raw : a_raw;
                    opb    <= (is_signed && b_raw[WIDTH-1]) ? -b_raw : b_raw;
                    neg_lo <= is_signed && (a_raw[WIDTH-1] ^ b_raw[WIDTH-1]);
                    neg_hi <= is_signed && a_raw[WIDTH-1];
                    acc    <= '0;
                    cnt    <= CW'(WIDTH);
                end
                S_RUN: begin
                    cnt <= cnt - CW'(1);
                    if (is_div) begin
                        acc <= {div_rem, acc[WIDTH-2:0], q_bit};
                        opa <= opa << 1;
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                        opb <= opb >> 1;
                    end
                end
                S_FIXUP: begin
                    if (!flush) begin
                        done        <= 1'b1;
                        div_by_zero <= zero_div;
                        if (!is_div) begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end else if (zero_div) begin
                            // Divide by zero reports all-ones quotient and the untouched dividend
                            hi <= a_raw;
                            lo <= '1;
                        end else begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
